// File: rtl/core_pkg.sv
// core_pkg -- definitions shared by the fetch-stage PC logic.
//   state_e   : PC unit control state (BOOT, RUN)
//   pc_sel_e  : next-PC source chosen by the priority encoder
//   DEF_*_VEC : default reset and trap-handler addresses
//   is_misaligned() : true when an address is not word aligned
package core_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    SEL_SEQ  = 3'd0,
    SEL_BR   = 3'd1,
    SEL_JMP  = 3'd2,
    SEL_TRAP = 3'd3,
    SEL_MRET = 3'd4,
    SEL_HOLD = 3'd5
  } pc_sel_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;

  // Only the two low address bits decide word alignment.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel -- combinational next-PC priority encoder.
// Ports:
//   i_trap, i_mret, i_jump, i_branch_taken : redirect requests
//   i_jump_lsb, i_branch_lsb               : low two bits of the redirect targets
//   i_fetch_ready, i_stall                 : handshake / hazard hold
//   o_sel                                  : chosen next-PC source
//   o_misaligned                           : selected jump/branch target is misaligned
// A misaligned jump/branch target is turned into SEL_TRAP here, so the
// register stage handles it exactly like a trap.
module pc_next_sel
  import core_pkg::*;
(
  input  logic       i_trap,
  input  logic       i_mret,
  input  logic       i_jump,
  input  logic       i_branch_taken,
  input  logic [1:0] i_jump_lsb,
  input  logic [1:0] i_branch_lsb,
  input  logic       i_fetch_ready,
  input  logic       i_stall,
  output pc_sel_e    o_sel,
  output logic       o_misaligned
);

  always_comb begin
    o_sel        = SEL_HOLD;
    o_misaligned = 1'b0;
    if (i_trap) begin
      o_sel = SEL_TRAP;
    end else if (i_mret) begin
      // Return address is trusted; no alignment check on epc.
      o_sel = SEL_MRET;
    end else if (i_jump) begin
      if (is_misaligned(i_jump_lsb)) begin
        o_sel        = SEL_TRAP;
        o_misaligned = 1'b1;
      end else begin
        o_sel = SEL_JMP;
      end
    end else if (i_branch_taken) begin
      if (is_misaligned(i_branch_lsb)) begin
        o_sel        = SEL_TRAP;
        o_misaligned = 1'b1;
      end else begin
        o_sel = SEL_BR;
      end
    end else if (i_fetch_ready && !i_stall) begin
      o_sel = SEL_SEQ;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit -- fetch-stage program counter with valid/ready fetch handshake.
// Parameters: XLEN (address width), RESET_VEC, TRAP_VEC, CNT_W (counter width).
// Ports:
//   clk, reset             : rising-edge clock, synchronous active-high reset
//   stall                  : hold sequential advance
//   branch_taken/_target   : taken conditional branch redirect
//   jump/jump_target       : JAL/JALR redirect
//   trap, mret             : trap entry / return
//   fetch_ready            : instruction memory accepts the current request
//   fetch_valid, pc        : fetch request toward memory
//   pc_plus4               : link value, pc + 4 (wraps)
//   epc                    : PC captured on trap or misaligned redirect
//   misaligned             : one-cycle pulse after a misaligned jump/branch
//   fetch_count            : accepted fetches, wraps
module pc_unit
  import core_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEF_TRAP_VEC),
  parameter int              CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  input  logic             jump,
  input  logic [XLEN-1:0]  jump_target,
  input  logic             trap,
  input  logic             mret,
  input  logic             fetch_ready,
  output logic             fetch_valid,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  output logic [XLEN-1:0]  epc,
  output logic             misaligned,
  output logic [CNT_W-1:0] fetch_count
);

  state_e            r_state;
  state_e            w_state_next;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_epc;
  logic              r_misaligned;
  logic [CNT_W-1:0]  r_fetch_count;
  logic [XLEN-1:0]   w_pc_plus4;
  logic              w_run;
  logic              w_accept;
  pc_sel_e           w_sel;
  logic              w_misaligned;

  assign w_run      = (r_state == RUN);
  assign w_pc_plus4 = r_pc + XLEN'(4);
  // Memory accepted the request; counts even when stalled or redirected.
  assign w_accept   = w_run && fetch_ready;

  pc_next_sel u_sel (
    .i_trap         (trap),
    .i_mret         (mret),
    .i_jump         (jump),
    .i_branch_taken (branch_taken),
    .i_jump_lsb     (jump_target[1:0]),
    .i_branch_lsb   (branch_target[1:0]),
    .i_fetch_ready  (fetch_ready),
    .i_stall        (stall),
    .o_sel          (w_sel),
    .o_misaligned   (w_misaligned)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state (BOOT lasts exactly one cycle)
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      BOOT:    w_state_next = RUN;
      RUN:     w_state_next = RUN;
      default: w_state_next = BOOT;
    endcase
  end

  // PC / EPC / misaligned pulse. Redirects are ignored while in BOOT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc         <= RESET_VEC;
      r_epc        <= '0;
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= w_run && w_misaligned;
      if (w_run) begin
        case (w_sel)
          SEL_TRAP: begin
            r_epc <= r_pc;
            r_pc  <= TRAP_VEC;
          end
          SEL_MRET: r_pc <= r_epc;
          SEL_JMP:  r_pc <= jump_target;
          SEL_BR:   r_pc <= branch_target;
          SEL_SEQ:  r_pc <= w_pc_plus4;
          default:  r_pc <= r_pc;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_count <= '0;
    end else if (w_accept) begin
      r_fetch_count <= r_fetch_count + CNT_W'(1);
    end
  end

  assign fetch_valid = w_run;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign epc         = r_epc;
  assign misaligned  = r_misaligned;
  assign fetch_count = r_fetch_count;

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the RISC-V core's fetch stage, replacing the plain loadable PC register. Holds the current fetch address and selects the next one from sequential, branch, jump, trap and trap-return sources. Runs a valid/ready fetch handshake toward instruction memory and captures the exception PC. Counts accepted fetches for performance monitoring.

## Interface
- XLEN, 32, address width in bits (≥ 8)
- RESET_VEC, 0, PC value after reset
- TRAP_VEC, 32'h0000_0100, handler address loaded on trap or misaligned redirect
- CNT_W, 32, fetch-counter width
- clk  input  1  rising-edge clock
- reset  input  1  reset, synchronous, active-high
- stall  input  1  hazard unit holds PC (sequential advance only)
- branch_taken  input  1  conditional branch resolved taken
- branch_target  input  XLEN  branch destination
- jump  input  1  JAL/JALR redirect
- jump_target  input  XLEN  jump destination
- trap  input  1  exception/interrupt request
- mret  input  1  return from trap
- fetch_ready  input  1  instruction memory accepts current request
- fetch_valid  output  1  request on pc is valid
- pc  output  XLEN  current fetch address
- pc_plus4  output  XLEN  pc + 4, combinational, for link register
- epc  output  XLEN  captured exception PC
- misaligned  output  1  one-cycle pulse: redirect target had bits [1:0] ≠ 0
- fetch_count  output  CNT_W  number of accepted fetches

## Operation
- States: BOOT, RUN. On reset: state = BOOT, pc = RESET_VEC, epc = 0, fetch_valid = 0, misaligned = 0, fetch_count = 0.
- BOOT → RUN unconditionally on the next clock. fetch_valid = 1 in RUN; pc holds during BOOT.
- Next-PC priority in RUN, highest first:
  - trap: pc ← TRAP_VEC, epc ← pc.
  - mret: pc ← epc.
  - jump: pc ← jump_target.
  - branch_taken: pc ← branch_target.
  - accept (fetch_ready && !stall): pc ← pc + 4.
  - otherwise: hold.
- Redirects (trap, mret, jump, branch) act as a flush. They apply on the next edge regardless of stall or fetch_ready; any unaccepted request is abandoned.
- Misaligned check applies to jump/branch targets only. If the selected target has bits [1:0] ≠ 0:
  - pc ← TRAP_VEC, epc ← pc.
  - misaligned = 1 for exactly one cycle.
- mret to a misaligned epc is not checked.
- fetch_count increments by 1 on every cycle with fetch_valid && fetch_ready. It increments even in a cycle where a redirect also occurs. It wraps modulo 2^CNT_W.
- pc + 4 wraps modulo 2^XLEN (all-ones-minus-3 → 0).
- Redirect inputs are ignored in BOOT.

## Timing
- All state updates occur on the rising edge of clk; reset has priority over every input.
- Redirect latency: target visible on pc one cycle after the input is asserted.
- Handshake: while fetch_valid && !fetch_ready with no redirect, pc is stable.
- Reset asserted mid-stall or mid-redirect returns to BOOT next edge. The pending redirect is lost.
- Simultaneous trap and jump: trap wins. epc captures the pc of that cycle, not the jump target.
- stall && fetch_ready: no advance, no count change unless fetch_valid && fetch_ready (counts; memory accepted).

## Structure
- Shared package core_pkg holds:
  - state encoding typedef (BOOT, RUN)
  - default RESET_VEC and TRAP_VEC constants
  - next-PC select enum (SEL_SEQ, SEL_BR, SEL_JMP, SEL_TRAP, SEL_MRET, SEL_HOLD)
- One sub-module: pc_next_sel. It is a combinational priority encoder producing the select enum and the misaligned flag. The pc/epc/counter registers and the FSM stay in pc_unit.

## Test plan
- Reset, then release: cycle 0 pc = 0, fetch_valid = 0; cycle 1 fetch_valid = 1. With fetch_ready = 1 each cycle, pc = 0, 4, 8; fetch_count = 3 after three accepts.
- fetch_ready = 0 for 3 cycles at pc = 8: pc stays 8, count unchanged. Then ready = 1 → pc = 12.
- jump = 1, jump_target = 0x40, same cycle as trap = 1 at pc = 0x10: pc = 0x100, epc = 0x10. Then mret → pc = 0x10.
- branch_taken with branch_target = 0x42: misaligned pulses one cycle, pc = 0x100, epc = branch-issuing pc.
- XLEN = 8, pc = 0xFC, accept → pc = 0x00. CNT_W = 4: 16 accepts → fetch_count = 0.
- Reset asserted during stall with branch_taken: pc = RESET_VEC, state BOOT, branch not applied.
